if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Accepts the PC value and its new-address strobe, issues one aligned 64-bit read to instruction memory and selects the 32-bit instruction word.
- Holds the instruction, its PC and a fault flag in an output register until the decode stage takes them.
- Back-pressures the PC register through fetch_stall_o; supports flush/redirect, including draining an outstanding response.

Parameters:
- ADDR_W, 64, PC and memory address width
- DATA_W, 64, instruction-memory read data width
- NOP_INST, 32'h00000013, instruction driven when no valid instruction or on fault

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- pc_i  in  ADDR_W  fetch address from PC register
- new_sign_i  in  1  pc_i carries a new address to fetch
- flush_i  in  1  redirect from ID/EX; kill everything in flight
- id_ready_i  in  1  decode accepts the held instruction this cycle
- req_valid_o  out  1  memory read request valid
- req_addr_o  out  ADDR_W  request address, 8-byte aligned
- req_ready_i  in  1  memory accepts request
- rsp_valid_i  in  1  read response valid
- rsp_data_i  in  DATA_W  read data
- rsp_err_i  in  1  bus error with response
- inst_o  out  32  instruction to decode
- inst_pc_o  out  ADDR_W  PC of inst_o
- inst_valid_o  out  1  inst_o/inst_pc_o/fault_o valid
- fault_o  out  1  misaligned PC or bus error for this instruction
- fetch_stall_o  out  1  fetch busy; PC register must hold

Behaviour:
- Reset (rst=1 at posedge):
  - state IDLE; req_valid_o=0, req_addr_o=0, inst_valid_o=0, inst_o=NOP_INST, inst_pc_o=0, fault_o=0.
  - A reset mid-transaction abandons it; responses arriving afterwards while in IDLE are ignored.
- States: IDLE, REQ, WAIT, DRAIN, HOLD. fetch_stall_o = (state != IDLE), combinational.
- flush_i has priority over every other event in every state.
- IDLE:
  - flush_i: stay.
  - new_sign_i with pc_i[1:0]==0: latch pc_i; req_valid_o<=1, req_addr_o<={pc_i[ADDR_W-1:3],3'b0}; go REQ.
  - new_sign_i with pc_i[1:0]!=0: no request; inst_valid_o<=1, fault_o<=1, inst_o<=NOP_INST, inst_pc_o<=pc_i; go HOLD.
- REQ:
  - req_valid_o and req_addr_o stay stable until req_ready_i.
  - req_ready_i: req_valid_o<=0; go WAIT, or DRAIN if flush_i.
  - flush_i without req_ready_i: withdraw request (req_valid_o<=0); go IDLE.
- WAIT:
  - rsp_valid_i without flush_i: inst_o<=latched pc[2] ? rsp_data_i[63:32] : rsp_data_i[31:0]; inst_pc_o<=latched pc; fault_o<=rsp_err_i; inst_valid_o<=1; go HOLD.
  - If rsp_err_i, inst_o<=NOP_INST.
  - flush_i with rsp_valid_i: discard response; go IDLE.
  - flush_i without rsp_valid_i: go DRAIN.
- DRAIN: wait for rsp_valid_i, discard data and error, go IDLE. Further flush_i has no extra effect.
- HOLD:
  - Outputs stable while id_ready_i=0.
  - id_ready_i or flush_i: inst_valid_o<=0, fault_o<=0, inst_o<=NOP_INST; go IDLE.
- At most one outstanding request; no new request before the previous response, including a drained one.
- Latency: new_sign_i accepted at edge N, req_valid_o high after N. With zero-wait memory (ready at N+1, response at N+2), inst_valid_o is high after edge N+3. A new PC is accepted no earlier than the cycle after the handoff.
- Whenever inst_valid_o=0, inst_o=NOP_INST.

Test Plan:
- Reset then pc_i=64'h8000_0000, new_sign_i=1; zero-wait memory returns 64'h0000_0093_0000_0013 -> req_addr_o=64'h8000_0000; inst_o=32'h00000013, inst_pc_o=64'h8000_0000, inst_valid_o=1 three cycles after acceptance; fetch_stall_o=1 from REQ until handoff.
- pc_i=64'h8000_0004, response data as above, id_ready_i=0 for 4 cycles -> req_addr_o=64'h8000_0000, inst_o=32'h00000093 held stable 4 cycles; cleared and IDLE the cycle after id_ready_i=1.
- req_ready_i held 0 for 5 cycles -> req_valid_o stays 1 with constant req_addr_o; flush_i on cycle 3 -> req_valid_o=0 next cycle, IDLE, no instruction issued.
- Flush one cycle after request acceptance, response 3 cycles later -> DRAIN, response discarded, inst_valid_o stays 0, next request issued only after the drained response.
- pc_i=64'h8000_0002 -> no memory request; inst_valid_o=1, fault_o=1, inst_o=32'h00000013, inst_pc_o=64'h8000_0002.
- rsp_err_i=1 with response -> fault_o=1, inst_o=NOP_INST. rst asserted during WAIT -> all outputs at reset values, later response ignored.

Source files
------------

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage: one aligned 64-bit read per PC, held until decode takes it
module if_fetch #(
    parameter int          ADDR_W   = 64,
    parameter int          DATA_W   = 64,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              new_sign_i,
    input  logic              flush_i,
    input  logic              id_ready_i,
    output logic              req_valid_o,
    output logic [ADDR_W-1:0] req_addr_o,
    input  logic              req_ready_i,
    input  logic              rsp_valid_i,
    input  logic [DATA_W-1:0] rsp_data_i,
    input  logic              rsp_err_i,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o,
    output logic              fault_o,
    output logic              fetch_stall_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN,
        S_HOLD
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              req_valid_q, req_valid_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [31:0]       inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic              inst_valid_q, inst_valid_d;
    logic              fault_q, fault_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            req_valid_q  <= 1'b0;
            req_addr_q   <= '0;
            inst_q       <= NOP_INST;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_valid_q  <= req_valid_d;
            req_addr_q   <= req_addr_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            fault_q      <= fault_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_valid_d  = req_valid_q;
        req_addr_d   = req_addr_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        fault_d      = fault_q;

        unique case (state_q)
            S_IDLE: begin
                if (!flush_i && new_sign_i) begin
                    if (pc_i[1:0] == 2'b00) begin
                        pc_d        = pc_i;
                        req_valid_d = 1'b1;
                        req_addr_d  = {pc_i[ADDR_W-1:3], 3'b000};
                        state_d     = S_REQ;
                    end else begin
                        // Misaligned PC faults immediately without touching memory.
                        inst_valid_d = 1'b1;
                        fault_d      = 1'b1;
                        inst_d       = NOP_INST;
                        inst_pc_d    = pc_i;
                        state_d      = S_HOLD;
                    end
                end
            end
            S_REQ: begin
                if (req_ready_i) begin
                    // An accepted request always returns a response, so a flush must drain it.
                    req_valid_d = 1'b0;
                    state_d     = flush_i ? S_DRAIN : S_WAIT;
                end else if (flush_i) begin
                    req_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            S_WAIT: begin
                if (flush_i) begin
                    state_d = rsp_valid_i ? S_IDLE : S_DRAIN;
                end else if (rsp_valid_i) begin
                    inst_d       = rsp_err_i ? NOP_INST
                                 : (pc_q[2] ? rsp_data_i[63:32] : rsp_data_i[31:0]);
                    inst_pc_d    = pc_q;
                    fault_d      = rsp_err_i;
                    inst_valid_d = 1'b1;
                    state_d      = S_HOLD;
                end
            end
            S_DRAIN: begin
                if (rsp_valid_i) begin
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (id_ready_i || flush_i) begin
                    inst_valid_d = 1'b0;
                    fault_d      = 1'b0;
                    inst_d       = NOP_INST;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign req_valid_o   = req_valid_q;
    assign req_addr_o    = req_addr_q;
    assign inst_o        = inst_q;
    assign inst_pc_o     = inst_pc_q;
    assign inst_valid_o  = inst_valid_q;
    assign fault_o       = fault_q;
    assign fetch_stall_o = (state_q != S_IDLE);

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - table-driven cycle vectors plus hand sequences for if_fetch
module tb_if_fetch;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [63:0] D   = 64'h0000_0093_0000_0013;
    localparam logic [63:0] A0  = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc_i;
    logic        new_sign_i, flush_i, id_ready_i;
    logic        req_valid_o;
    logic [63:0] req_addr_o;
    logic        req_ready_i, rsp_valid_i, rsp_err_i;
    logic [63:0] rsp_data_i;
    logic [31:0] inst_o;
    logic [63:0] inst_pc_o;
    logic        inst_valid_o, fault_o, fetch_stall_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .new_sign_i   (new_sign_i),
        .flush_i      (flush_i),
        .id_ready_i   (id_ready_i),
        .req_valid_o  (req_valid_o),
        .req_addr_o   (req_addr_o),
        .req_ready_i  (req_ready_i),
        .rsp_valid_i  (rsp_valid_i),
        .rsp_data_i   (rsp_data_i),
        .rsp_err_i    (rsp_err_i),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_valid_o (inst_valid_o),
        .fault_o      (fault_o),
        .fetch_stall_o(fetch_stall_o)
    );

    typedef struct packed {
        logic        rst, ns;
        logic [63:0] pc;
        logic        fl, idr, rrdy, rv, rerr;
        logic        e_rv;
        logic [63:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [63:0] e_ipc;
        logic        e_flt, e_stall;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic r, logic ns, logic [63:0] pc, logic fl, logic idr,
                               logic rrdy, logic rv, logic rerr, logic e_rv, logic [63:0] e_addr,
                               logic e_iv, logic [31:0] e_inst, logic [63:0] e_ipc,
                               logic e_flt, logic e_stall);
        vec_t t;
        t = '{r, ns, pc, fl, idr, rrdy, rv, rerr, e_rv, e_addr, e_iv, e_inst, e_ipc, e_flt, e_stall};
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        rst = 1'b0; new_sign_i = 1'b0; pc_i = '0; flush_i = 1'b0; id_ready_i = 1'b0;
        req_ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_data_i = D; rsp_err_i = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k_exit;
        clear_inputs();

        //           rst ns pc                fl idr rrdy rv err | rv addr              iv inst          ipc               flt stall
        // Aligned fetch, zero-wait memory, low word
        vecs.push_back(v(1, 0, 64'h0,           0, 0, 0, 0, 0,    0, 64'h0,            0, NOP,          64'h0,            0, 0));
        vecs.push_back(v(0, 1, A0,              0, 0, 0, 0, 0,    1, A0,               0, NOP,          64'h0,            0, 1));
        vecs.push_back(v(0, 0, 64'h0,           0, 0, 1, 0, 0,    0, A0,               0, NOP,          64'h0,            0, 1));
        vecs.push_back(v(0, 0, 64'h0,           0, 0, 0, 0, 0,    0, A0,               0, NOP,          64'h0,            0, 1));
        vecs.push_back(v(0, 0, 64'h0,           0, 0, 0, 1, 0,    0, A0,               1, 32'h00000013, A0,               0, 1));
        vecs.push_back(v(0, 0, 64'h0,           0, 1, 0, 0, 0,    0, A0,               0, NOP,          A0,               0, 0));
        // High word, decode stalls 4 cycles; new PC during handoff is ignored
        vecs.push_back(v(0, 1, 64'h8000_0004,   0, 0, 0, 0, 0,    1, A0,               0, NOP,          A0,               0, 1));
        vecs.push_back(v(0, 0, 64'h0,           0, 0, 1, 0, 0,    0, A0,               0, NOP,          A0,               0, 1));
        vecs.push_back(v(0, 0, 64'h0,           0, 0, 0, 1, 0,    0, A0,               1, 32'h00000093, 64'h8000_0004,    0, 1));
        vecs.push_back(v(0, 0, 64'h0,           0, 0, 0, 0, 0,    0, A0,               1, 32'h00000093, 64'h8000_0004,    0, 1));
        vecs.push_back(v(0, 0, 64'h0,           0, 0, 0, 0, 0,    0, A0,               1, 32'h00000093, 64'h8000_0004,    0, 1));
        vecs.push_back(v(0, 0, 64'h0,           0, 0, 0, 0, 0,    0, A0,               1, 32'h00000093, 64'h8000_0004,    0, 1));
        vecs.push_back(v(0, 1, 64'h8000_0010,   0, 1, 0, 0, 0,    0, A0,               0, NOP,          64'h8000_0004,    0, 0));
        vecs.push_back(v(0, 1, 64'h8000_0010,   0, 0, 0, 0, 0,    1, 64'h8000_0010,    0, NOP,          64'h8000_0004,    0, 1));
        // Request not accepted, flush withdraws it
        vecs.push_back(v(0, 0, 64'h0,           0, 0, 0, 0, 0,    1, 64'h8000_0010,    0, NOP,          64'h8000_0004,    0, 1));
        vecs.push_back(v(0, 0, 64'h0,           1, 0, 0, 0, 0,    0, 64'h8000_0010,    0, NOP,          64'h8000_0004,    0, 0));
        vecs.push_back(v(0, 0, 64'h0,           0, 0, 0, 0, 0,    0, 64'h8000_0010,    0, NOP,          64'h8000_0004,    0, 0));
        // Flush in WAIT drains the outstanding response
        vecs.push_back(v(0, 1, 64'h8000_0008,   0, 0, 0, 0, 0,    1, 64'h8000_0008,    0, NOP,          64'h8000_0004,    0, 1));
        vecs.push_back(v(0, 0, 64'h0,           0, 0, 1, 0, 0,    0, 64'h8000_0008,    0, NOP,          64'h8000_0004,    0, 1));
        vecs.push_back(v(0, 0, 64'h0,           1, 0, 0, 0, 0,    0, 64'h8000_0008,    0, NOP,          64'h8000_0004,    0, 1));
        vecs.push_back(v(0, 1, 64'h8000_0020,   0, 0, 0, 0, 0,    0, 64'h8000_0008,    0, NOP,          64'h8000_0004,    0, 1));
        vecs.push_back(v(0, 0, 64'h0,           1, 0, 0, 0, 0,    0, 64'h8000_0008,    0, NOP,          64'h8000_0004,    0, 1));
        vecs.push_back(v(0, 0, 64'h0,           0, 0, 0, 1, 0,    0, 64'h8000_0008,    0, NOP,          64'h8000_0004,    0, 0));
        vecs.push_back(v(0, 1, 64'h8000_0020,   0, 0, 0, 0, 0,    1, 64'h8000_0020,    0, NOP,          64'h8000_0004,    0, 1));
        // Flush coinciding with acceptance, then flush with the drained response
        vecs.push_back(v(0, 0, 64'h0,           1, 0, 1, 0, 0,    0, 64'h8000_0020,    0, NOP,          64'h8000_0004,    0, 1));
        vecs.push_back(v(0, 0, 64'h0,           1, 0, 0, 1, 0,    0, 64'h8000_0020,    0, NOP,          64'h8000_0004,    0, 0));
        // Misaligned PC: fault without a request; flush releases it
        vecs.push_back(v(0, 1, 64'h8000_0002,   0, 0, 0, 0, 0,    0, 64'h8000_0020,    1, NOP,          64'h8000_0002,    1, 1));
        vecs.push_back(v(0, 0, 64'h0,           1, 0, 0, 0, 0,    0, 64'h8000_0020,    0, NOP,          64'h8000_0002,    0, 0));
        // Bus error response
        vecs.push_back(v(0, 1, 64'h8000_0004,   0, 0, 0, 0, 0,    1, A0,               0, NOP,          64'h8000_0002,    0, 1));
        vecs.push_back(v(0, 0, 64'h0,           0, 0, 1, 0, 0,    0, A0,               0, NOP,          64'h8000_0002,    0, 1));
        vecs.push_back(v(0, 0, 64'h0,           0, 0, 0, 1, 1,    0, A0,               1, NOP,          64'h8000_0004,    1, 1));
        vecs.push_back(v(0, 0, 64'h0,           0, 1, 0, 0, 0,    0, A0,               0, NOP,          64'h8000_0004,    0, 0));
        // Flush with response in WAIT discards it
        vecs.push_back(v(0, 1, A0,              0, 0, 0, 0, 0,    1, A0,               0, NOP,          64'h8000_0004,    0, 1));
        vecs.push_back(v(0, 0, 64'h0,           0, 0, 1, 0, 0,    0, A0,               0, NOP,          64'h8000_0004,    0, 1));
        vecs.push_back(v(0, 0, 64'h0,           1, 0, 0, 1, 0,    0, A0,               0, NOP,          64'h8000_0004,    0, 0));
        // Reset during WAIT; late response and flushed new_sign are ignored
        vecs.push_back(v(0, 1, 64'h8000_000C,   0, 0, 0, 0, 0,    1, 64'h8000_0008,    0, NOP,          64'h8000_0004,    0, 1));
        vecs.push_back(v(0, 0, 64'h0,           0, 0, 1, 0, 0,    0, 64'h8000_0008,    0, NOP,          64'h8000_0004,    0, 1));
        vecs.push_back(v(1, 0, 64'h0,           0, 0, 0, 0, 0,    0, 64'h0,            0, NOP,          64'h0,            0, 0));
        vecs.push_back(v(0, 0, 64'h0,           0, 0, 0, 1, 0,    0, 64'h0,            0, NOP,          64'h0,            0, 0));
        vecs.push_back(v(0, 1, A0,              1, 0, 0, 0, 0,    0, 64'h0,            0, NOP,          64'h0,            0, 0));
        vecs.push_back(v(0, 0, 64'h0,           0, 0, 0, 0, 0,    0, 64'h0,            0, NOP,          64'h0,            0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; new_sign_i = vecs[i].ns; pc_i = vecs[i].pc;
            flush_i = vecs[i].fl; id_ready_i = vecs[i].idr; req_ready_i = vecs[i].rrdy;
            rsp_valid_i = vecs[i].rv; rsp_err_i = vecs[i].rerr; rsp_data_i = D;
            step();
            chk($sformatf("row%0d req_valid", i),  {63'b0, req_valid_o},   {63'b0, vecs[i].e_rv});
            chk($sformatf("row%0d req_addr", i),   req_addr_o,              vecs[i].e_addr);
            chk($sformatf("row%0d inst_valid", i), {63'b0, inst_valid_o},  {63'b0, vecs[i].e_iv});
            chk($sformatf("row%0d inst", i),       {32'b0, inst_o},        {32'b0, vecs[i].e_inst});
            chk($sformatf("row%0d inst_pc", i),    inst_pc_o,               vecs[i].e_ipc);
            chk($sformatf("row%0d fault", i),      {63'b0, fault_o},       {63'b0, vecs[i].e_flt});
            chk($sformatf("row%0d stall", i),      {63'b0, fetch_stall_o}, {63'b0, vecs[i].e_stall});
        end

        // Request held 5 cycles without ready: stable valid/address, then high-word fetch
        @(negedge clk); clear_inputs(); new_sign_i = 1'b1; pc_i = 64'h8000_0014;
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); clear_inputs();
            step();
            chk($sformatf("hold_req%0d valid", i), {63'b0, req_valid_o}, 64'd1);
            chk($sformatf("hold_req%0d addr", i),  req_addr_o, 64'h8000_0010);
        end
        @(negedge clk); clear_inputs(); req_ready_i = 1'b1;
        step();
        chk("hold_req accepted", {63'b0, req_valid_o}, 64'd0);
        @(negedge clk); clear_inputs(); rsp_valid_i = 1'b1; rsp_data_i = 64'hDEAD_BEEF_0000_0013;
        step();
        chk("hi_word inst", {32'b0, inst_o}, 64'h0000_0000_DEAD_BEEF);
        chk("hi_word pc", inst_pc_o, 64'h8000_0014);
        @(negedge clk); clear_inputs(); id_ready_i = 1'b1;
        step();
        chk("hi_word release", {32'b0, inst_o}, {32'b0, NOP});

        // Drain with a late response; PC must not be accepted until it arrives
        @(negedge clk); clear_inputs(); new_sign_i = 1'b1; pc_i = 64'h8000_0018;
        step();
        @(negedge clk); clear_inputs(); req_ready_i = 1'b1;
        step();
        @(negedge clk); clear_inputs(); flush_i = 1'b1;
        step();
        chk("drain stall", {63'b0, fetch_stall_o}, 64'd1);
        k_exit = 99;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); clear_inputs(); new_sign_i = 1'b1; pc_i = 64'h8000_0030;
            rsp_valid_i = (k == 2);
            step();
            chk($sformatf("drain%0d inst_valid", k), {63'b0, inst_valid_o}, 64'd0);
            chk($sformatf("drain%0d req_valid", k),  {63'b0, req_valid_o}, 64'd0);
            if (!fetch_stall_o) begin
                k_exit = k;
                break;
            end
        end
        chk("drain exit cycle", 64'(k_exit), 64'd2);
        @(negedge clk); clear_inputs(); new_sign_i = 1'b1; pc_i = 64'h8000_0030;
        step();
        chk("post_drain req_valid", {63'b0, req_valid_o}, 64'd1);
        chk("post_drain req_addr", req_addr_o, 64'h8000_0030);
        @(negedge clk); clear_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
